serial_add_ctrl: RTL

- Multi-cycle sequencer that reuses one narrow SLICE-bit ripple-carry adder slice to add two WIDTH-bit operands, one slice per clock, LSB slice first.
- Carry is held in a register between cycles.
- Sits between a requester (valid/ready operand port) and a consumer (valid/ready result port).
- Trades latency for area relative to a full-width combinational adder.

---
 rtl/serial_add_pkg.sv | 25 ++
 rtl/slice_adder.sv | 33 +++
 rtl/serial_add_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the slice-serial adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: controller state enum and helpers that derive the slice count
// and slice-index counter width from WIDTH/SLICE.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slices needed to cover the full operand width.
    function automatic int calc_nslices(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice index counter width: ceil(log2(n)), never narrower than 1 bit.
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slice_adder.sv
// Narrow ripple-carry adder slice shared by the serial add controller.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   cin  - carry into bit 0
//   a, b - SLICE-bit addends
//   s    - SLICE-bit sum
//   cout - carry out of the top bit
module slice_adder #(
    parameter int SLICE = 4
) (
    input  logic             cin,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    // c[i] is the carry into bit i; c[SLICE] leaves the slice.
    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        // One full-adder cell per bit.
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[SLICE];

endmodule

// File: rtl/serial_add_ctrl.sv
// Adds two WIDTH-bit operands one SLICE-bit slice per clock, LSB slice first.
// Latency: out_valid rises WIDTH/SLICE edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
//
// Ports:
//   clk, rst            - clock (rising edge), async active-high reset
//   in_valid/in_ready   - operand handshake; a, b, cin sampled on accept
//   sub                 - subtract select, present only with SERIAL_ADD_CTRL_SUB_EN
//   out_valid/out_ready - result handshake; sum, cout stable while out_valid
//   busy                - high while an operation is in RUN or DONE
//
// Optional feature macro: SERIAL_ADD_CTRL_SUB_EN (adds the sub port; when
// sub=1 the result is a - b with cout=1 meaning no borrow).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_CTRL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICES = calc_nslices(WIDTH, SLICE);
    localparam int IDXW    = calc_idx_w(NSLICES);
    localparam logic [IDXW-1:0] LAST_K = IDXW'(NSLICES - 1);

    state_t             state_q, state_d;
    logic [IDXW-1:0]    k_q, k_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [SLICE-1:0]   slc_a, slc_b, slc_s;
    logic               slc_co;

    // Effective B and carry-in at accept time; subtraction is a + ~b + 1.
    logic [WIDTH-1:0]   b_in;
    logic               carry_in;

`ifdef SERIAL_ADD_CTRL_SUB_EN
    assign b_in     = sub ? ~b : b;
    assign carry_in = sub ? 1'b1 : cin;
`else
    assign b_in     = b;
    assign carry_in = cin;
`endif

    assign slc_a = a_q[k_q*SLICE +: SLICE];
    assign slc_b = b_q[k_q*SLICE +: SLICE];

    slice_adder #(
        .SLICE (SLICE)
    ) u_slice (
        .cin  (carry_q),
        .a    (slc_a),
        .b    (slc_b),
        .s    (slc_s),
        .cout (slc_co)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_in;
                    carry_d = carry_in;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*SLICE +: SLICE] = slc_s;
                carry_d = slc_co;
                if (k_q == LAST_K) begin
                    cout_d  = slc_co;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + IDXW'(1);
                end
            end
            DONE: begin
                // sum/cout stay put after the handshake until the next run.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
